uart_rx_parity: RTL and testbench
=================================

UART_RX_PARITY -- requirements
Module: uart_rx_parity

Interface
REQ-001 Parameter DATA_WIDTH, default 8: number of data bits per frame.
REQ-002 Parameter OVERSAMPLE, default 16: UCLK cycles per bit period; must be even and at least 4.
REQ-003 UCLK  input  1  receiver clock; the single clock; all logic is rising-edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 rx_in  input  1  asynchronous serial line; idle high.
REQ-006 parity_en  input  1  when 1, the frame carries one odd-parity bit after the data bits.
REQ-007 rx_data  output  DATA_WIDTH  last received data word.
REQ-008 data_valid  output  1  one-cycle pulse marking that rx_data and the error flags are updated.
REQ-009 parity_error  output  1  the last frame's parity bit mismatched; 0 when parity was disabled for that frame.
REQ-010 framing_error  output  1  the last frame's stop bit was sampled 0.

Function
REQ-011 rx_in shall pass through a 2-flop synchronizer (rx_sync) before any use; both flops reset to 1.
REQ-012 The FSM states shall be IDLE, START, DATA, PARITY, STOP and BREAK.
- A bit counter cnt runs 0..OVERSAMPLE-1 within each bit.
- The sample point is cnt == OVERSAMPLE/2-1.
- The bit ends at cnt == OVERSAMPLE-1.
REQ-013 IDLE: when rx_sync==0, the FSM goes to START with cnt=0, and parity_en is latched for the whole frame.
REQ-014 START: at the sample point, rx_sync==1 is a glitch and the FSM returns to IDLE with no outputs changed; otherwise it continues, and at the bit end it goes to DATA with cnt=0 and the bit index at 0.
REQ-015 DATA: at each sample point, rx_sync is shifted into bit[index], LSB first. At the bit end of index DATA_WIDTH-1, the FSM goes to PARITY if latched parity_en==1, else to STOP.
REQ-016 PARITY: at the sample point, the received bit is stored; at the bit end the FSM goes to STOP.
- Expected parity = ~^(received data), odd parity.
- Mismatch sets the pending parity error.
REQ-017 STOP: at the sample point, in the same cycle, the block shall:
- set rx_data to the shift register;
- pulse data_valid for exactly 1 cycle;
- set parity_error to the pending parity error;
- set framing_error to (rx_sync==0).
REQ-018 STOP exit, decided at the same sample point: if rx_sync==1, the FSM goes to IDLE in the next cycle, which allows a start bit half a bit later. If rx_sync==0, it goes to BREAK.
REQ-019 BREAK: the FSM stays until rx_sync==1, then goes to IDLE; a continuous low line shall not generate further frames.
REQ-020 data_valid shall pulse even when a frame has errors.
REQ-021 rx_data, parity_error and framing_error shall hold their values until the next data_valid pulse.
REQ-022 Changes to parity_en in mid-frame shall have no effect on the current frame.
REQ-023 The shift register and pending parity flag shall clear on entry to START.
REQ-024 Nominal latency from rx_sync first 0 to the data_valid pulse = OVERSAMPLE*(1+DATA_WIDTH+parity_en) + OVERSAMPLE/2 cycles.

Reset
REQ-025 While reset==1, on each UCLK edge the block shall:
- set the FSM to IDLE;
- set cnt and the bit index to 0;
- set rx_data to 0;
- set data_valid, parity_error and framing_error to 0;
- set the synchronizer flops to 1.
REQ-026 Reset asserted mid-frame shall abort the frame with no data_valid; after release, the block shall wait in IDLE for the next rx_sync falling edge.

Verification
REQ-027 Default parameters, parity_en=0, frame 0xA5 with stop=1 -> exactly one data_valid pulse, rx_data=0xA5, parity_error=0, framing_error=0.
REQ-028 parity_en=1, frame 0x3C with parity bit 1 -> rx_data=0x3C, parity_error=0; the same frame with parity bit 0 -> parity_error=1.
REQ-029 rx_in low for 4 UCLK cycles, then high -> the FSM returns to IDLE with no data_valid, and all outputs unchanged.
REQ-030 Frame 0x55 with stop bit 0 and the line held low for 5 bit periods -> one data_valid with framing_error=1, no further pulses, and the next valid frame 0x81 is received correctly.
REQ-031 Back-to-back frames 0x01, 0xFE with no idle gap -> two data_valid pulses, both rx_data values correct, no errors.
REQ-032 Reset pulsed during bit 4 of a frame -> no data_valid, all outputs 0, and a following frame 0x7E is received correctly.

Source files
------------

// File: rtl/uart_rx_parity.sv
// UART receiver with optional odd parity.
// Oversamples the line at OVERSAMPLE clocks per bit, samples each bit at its
// midpoint and reports every frame, including frames with parity or framing
// errors. A line held low after a bad stop bit is treated as a break and does
// not produce further frames until it returns high.
module uart_rx_parity #(
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                  UCLK,
  input  logic                  reset,
  input  logic                  rx_in,
  input  logic                  parity_en,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  data_valid,
  output logic                  parity_error,
  output logic                  framing_error
);

  localparam int CW = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
  localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [CW-1:0] C_SAMPLE = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] C_END    = CW'(OVERSAMPLE - 1);
  localparam logic [IW-1:0] C_LAST   = IW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  state_t                r_state;
  logic [CW-1:0]         r_cnt;
  logic [IW-1:0]         r_idx;
  logic                  r_sync1;
  logic                  r_sync2;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_par_en;
  logic                  r_par_err;
  logic [DATA_WIDTH-1:0] r_rx_data;
  logic                  r_data_valid;
  logic                  r_parity_error;
  logic                  r_framing_error;

  logic w_rx;
  logic w_sample;
  logic w_end;

  assign w_rx     = r_sync2;
  assign w_sample = (r_cnt == C_SAMPLE);
  assign w_end    = (r_cnt == C_END);

  assign rx_data       = r_rx_data;
  assign data_valid    = r_data_valid;
  assign parity_error  = r_parity_error;
  assign framing_error = r_framing_error;

  // Two-flop synchronizer for the asynchronous line; resets to the idle level.
  always_ff @(posedge UCLK) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx_in;
      r_sync2 <= r_sync1;
    end
  end

  // Frame FSM: bit timing, data shift-in, parity check and registered results.
  always_ff @(posedge UCLK) begin
    if (reset) begin
      r_state         <= S_IDLE;
      r_cnt           <= '0;
      r_idx           <= '0;
      r_rx_data       <= '0;
      r_data_valid    <= 1'b0;
      r_parity_error  <= 1'b0;
      r_framing_error <= 1'b0;
    end else begin
      r_data_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          r_idx <= '0;
          if (!w_rx) begin
            // parity_en is captured once so mid-frame changes cannot affect it
            r_state   <= S_START;
            r_par_en  <= parity_en;
            r_shift   <= '0;
            r_par_err <= 1'b0;
          end
        end

        S_START: begin
          if (w_sample && w_rx) begin
            // line went back high before mid-bit: a glitch, not a start bit
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end else if (w_end) begin
            r_state <= S_DATA;
            r_cnt   <= '0;
            r_idx   <= '0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end

        S_DATA: begin
          // LSB arrives first, so after the last bit it sits at position 0
          if (w_sample) begin
            r_shift <= {w_rx, r_shift[DATA_WIDTH-1:1]};
          end
          if (w_end) begin
            r_cnt <= '0;
            if (r_idx == C_LAST) begin
              r_idx   <= '0;
              r_state <= r_par_en ? S_PARITY : S_STOP;
            end else begin
              r_idx <= r_idx + IW'(1);
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end

        S_PARITY: begin
          // odd parity: the parity bit must equal the XNOR of the data bits
          if (w_sample) begin
            r_par_err <= (w_rx != ~^r_shift);
          end
          if (w_end) begin
            r_state <= S_STOP;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end

        S_STOP: begin
          // results are published at mid stop bit so a following start bit
          // half a bit later is still caught from IDLE
          if (w_sample) begin
            r_rx_data       <= r_shift;
            r_data_valid    <= 1'b1;
            r_parity_error  <= r_par_err;
            r_framing_error <= ~w_rx;
            r_state         <= w_rx ? S_IDLE : S_BREAK;
            r_cnt           <= '0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end

        S_BREAK: begin
          // wait for the line to recover so a held-low line yields one frame only
          r_cnt <= '0;
          if (w_rx) begin
            r_state <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_parity.sv
// Self-checking bench for uart_rx_parity: directed frames plus random frames,
// compared against a frame-level model of what the receiver must report.
module tb_uart_rx_parity;

  localparam int DW = 8;
  localparam int OS = 16;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } frame_t;

  logic          UCLK;
  logic          reset;
  logic          rx_in;
  logic          parity_en;
  logic [DW-1:0] rx_data;
  logic          data_valid;
  logic          parity_error;
  logic          framing_error;

  int errors = 0;
  int checks = 0;

  frame_t got_q[$];
  frame_t exp_q[$];
  frame_t last_exp;
  logic   prev_dv = 1'b0;
  int     dv_long = 0;

  uart_rx_parity #(.DATA_WIDTH(DW), .OVERSAMPLE(OS)) dut (
    .UCLK          (UCLK),
    .reset         (reset),
    .rx_in         (rx_in),
    .parity_en     (parity_en),
    .rx_data       (rx_data),
    .data_valid    (data_valid),
    .parity_error  (parity_error),
    .framing_error (framing_error)
  );

  initial UCLK = 1'b0;
  always #5 UCLK = ~UCLK;

  // Capture every reported frame away from the active edge.
  always @(negedge UCLK) begin
    frame_t f;
    if (data_valid) begin
      f.d  = rx_data;
      f.pe = parity_error;
      f.fe = framing_error;
      got_q.push_back(f);
      if (prev_dv) dv_long <= dv_long + 1;
    end
    prev_dv <= data_valid;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Hold the line at level b for n clocks, stepping just after each rising edge.
  task automatic hold(input logic b, input int n);
    rx_in = b;
    repeat (n) begin
      @(posedge UCLK);
      #1;
    end
  endtask

  // Model: what the receiver must report for one transmitted frame.
  task automatic expect_frame(input logic [7:0] d, input logic pen, input logic pbit,
                              input logic stop);
    frame_t f;
    f.d  = d;
    // odd parity means data ones plus parity bit must be an odd count
    f.pe = pen && ((($countones(d) + int'(pbit)) % 2) == 0);
    f.fe = (stop == 1'b0);
    exp_q.push_back(f);
    last_exp = f;
  endtask

  // Transmit one frame; parity_en is scrambled after the start bit to show
  // that only the value at frame start matters.
  task automatic send_frame(input logic [7:0] d, input logic pen, input logic pbit,
                            input logic stop);
    expect_frame(d, pen, pbit, stop);
    parity_en = pen;
    hold(1'b0, OS);
    parity_en = 1'($urandom_range(0, 1));
    for (int i = 0; i < DW; i++) hold(d[i], OS);
    if (pen) hold(pbit, OS);
    hold(stop, OS);
  endtask

  task automatic check_frames(input string tag);
    frame_t g;
    frame_t e;
    chk({tag, " pulses"}, 32'(got_q.size()), 32'(exp_q.size()));
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      chk({tag, " rx_data"}, 32'(g.d), 32'(e.d));
      chk({tag, " parity_error"}, 32'(g.pe), 32'(e.pe));
      chk({tag, " framing_error"}, 32'(g.fe), 32'(e.fe));
    end
    got_q.delete();
    exp_q.delete();
    // outputs must still hold the most recent frame's values
    chk({tag, " hold rx_data"}, 32'(rx_data), 32'(last_exp.d));
    chk({tag, " hold parity_error"}, 32'(parity_error), 32'(last_exp.pe));
    chk({tag, " hold framing_error"}, 32'(framing_error), 32'(last_exp.fe));
  endtask

  initial begin
    logic [7:0] d;
    logic       pen;
    logic       pbit;
    logic       stop;

    reset     = 1'b1;
    rx_in     = 1'b1;
    parity_en = 1'b0;
    last_exp.d  = '0;
    last_exp.pe = 1'b0;
    last_exp.fe = 1'b0;

    // reset state
    hold(1'b1, 4);
    chk("reset rx_data", 32'(rx_data), 32'h0);
    chk("reset data_valid", 32'(data_valid), 32'h0);
    chk("reset parity_error", 32'(parity_error), 32'h0);
    chk("reset framing_error", 32'(framing_error), 32'h0);
    reset = 1'b0;
    hold(1'b1, 2 * OS);
    check_frames("idle");

    // plain frame without parity
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
    hold(1'b1, OS);
    check_frames("A5 no parity");

    // parity correct, then parity wrong
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1);
    hold(1'b1, OS);
    check_frames("3C good parity");
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1);
    hold(1'b1, OS);
    check_frames("3C bad parity");

    // short low glitch is not a start bit; outputs keep the last frame
    hold(1'b0, 4);
    hold(1'b1, 2 * OS);
    check_frames("glitch");

    // bad stop bit followed by a long low line, then a good frame
    send_frame(8'h55, 1'b0, 1'b0, 1'b0);
    hold(1'b0, 5 * OS);
    hold(1'b1, 2 * OS);
    check_frames("55 break");
    send_frame(8'h81, 1'b0, 1'b0, 1'b1);
    hold(1'b1, OS);
    check_frames("81 after break");

    // back-to-back frames with no idle gap
    send_frame(8'h01, 1'b0, 1'b0, 1'b1);
    send_frame(8'hFE, 1'b0, 1'b0, 1'b1);
    hold(1'b1, OS);
    check_frames("back-to-back");

    // reset during data bit 4 aborts the frame
    d = 8'h3B;
    parity_en = 1'b0;
    hold(1'b0, OS);
    for (int i = 0; i < 4; i++) hold(d[i], OS);
    hold(d[4], 5);
    rx_in = 1'b1;
    reset = 1'b1;
    hold(1'b1, 3);
    reset = 1'b0;
    last_exp.d  = '0;
    last_exp.pe = 1'b0;
    last_exp.fe = 1'b0;
    hold(1'b1, 2 * OS);
    check_frames("mid-frame reset");
    send_frame(8'h7E, 1'b0, 1'b0, 1'b1);
    hold(1'b1, OS);
    check_frames("7E after reset");

    // random frames with random parity, errors and gaps
    for (int n = 0; n < 16; n++) begin
      d    = 8'($urandom);
      pen  = 1'($urandom_range(0, 1));
      pbit = 1'($urandom_range(0, 1));
      stop = ($urandom_range(0, 3) != 0);
      send_frame(d, pen, pbit, stop);
      if (!stop) begin
        hold(1'b0, OS);
        hold(1'b1, 2 * OS);
      end else begin
        hold(1'b1, $urandom_range(0, 2) * OS);
      end
      check_frames("random");
    end

    hold(1'b1, 2);
    chk("data_valid single cycle", 32'(dv_long), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
